// File: rtl/rr_stream_mux_pkg.sv
// Shared constants, index type and width helper for the round-robin stream mux.
// The optional per-beat last/lock feature is controlled by RR_STREAM_MUX_LAST_EN.
package rr_stream_mux_pkg;

    localparam int DEF_N_CH  = 4;
    localparam int DEF_WIDTH = 8;
    localparam int MAX_CH_W  = 4;

    typedef logic [MAX_CH_W-1:0] ch_idx_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_stream_mux_arbiter.sv
// Combinational rotate-priority arbiter: the first requester after ptr wins.
// Grants only while en is high; gnt is one-hot or zero.
module rr_arbiter
    import rr_stream_mux_pkg::*;
#(
    parameter  int N_CH = DEF_N_CH,
    localparam int CH_W = clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    input  logic            en,
    output logic [N_CH-1:0] gnt,
    output logic [CH_W-1:0] gnt_idx
);

    int   w_dist;
    int   w_best;
    int   w_sel;
    logic w_found;

    // Distance 0 is the channel right after ptr; the smallest distance among requesters wins.
    always_comb begin
        w_dist  = 0;
        w_best  = N_CH;
        w_sel   = 0;
        w_found = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            w_dist = (i + 2 * N_CH - 1 - int'(ptr)) % N_CH;
            if (en && req[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_sel   = i;
                w_found = 1'b1;
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            gnt[i] = w_found && (i == w_sel);
        end
        gnt_idx = CH_W'(w_sel);
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N:1 valid/ready stream mux with round-robin fairness and a single registered output slot.
// Define RR_STREAM_MUX_LAST_EN to add in_last/out_last and lock the grant to a packet.
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter  int N_CH  = DEF_N_CH,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int CH_W  = clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
`ifdef RR_STREAM_MUX_LAST_EN
    input  logic [N_CH-1:0]       in_last,
    output logic                  out_last,
`endif
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [CH_W-1:0]       out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [CH_W-1:0]  r_ptr;
    logic [WIDTH-1:0] r_data;
    logic [CH_W-1:0]  r_ch;
    logic             r_valid;

    logic             w_slot_free;
    logic             w_en;
    logic             w_xfer;
    logic [N_CH-1:0]  w_req;
    logic [N_CH-1:0]  w_gnt;
    logic [CH_W-1:0]  w_gnt_idx;
    logic [WIDTH-1:0] w_sel_data;

    assign w_slot_free = !r_valid || out_ready;
    assign w_en        = w_slot_free && !rst;

`ifdef RR_STREAM_MUX_LAST_EN
    logic r_lock;
    logic r_last;
    logic w_last;

    // While a packet is open, only its channel (the last one transferred) may be granted.
    always_comb begin
        w_req = in_valid;
        if (r_lock) begin
            w_req = in_valid & (N_CH'(1) << r_ch);
        end
    end

    assign w_last   = |(in_last & w_gnt);
    assign out_last = r_last;
`else
    assign w_req = in_valid;
`endif

    rr_arbiter #(
        .N_CH    (N_CH)
    ) u_arb (
        .req     (w_req),
        .ptr     (r_ptr),
        .en      (w_en),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_gnt[i]) begin
                w_sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_xfer   = |w_gnt;
    assign in_ready = w_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
            r_ptr   <= CH_W'(N_CH - 1);
`ifdef RR_STREAM_MUX_LAST_EN
            r_lock  <= 1'b0;
            r_last  <= 1'b0;
`endif
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_sel_data;
            r_ch    <= w_gnt_idx;
`ifdef RR_STREAM_MUX_LAST_EN
            r_last  <= w_last;
            r_lock  <= !w_last;
            if (w_last) begin
                r_ptr <= w_gnt_idx;
            end
`else
            r_ptr   <= w_gnt_idx;
`endif
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_ch    = r_ch;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: expected beats are queued at grant time and popped on output handshake.
// Build with RR_STREAM_MUX_LAST_EN defined to exercise the packet-lock scenario as well.
module tb_rr_stream_mux;

    localparam int N_CH  = 4;
    localparam int WIDTH = 8;
    localparam int CH_W  = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic [WIDTH-1:0]      out_data;
    logic [CH_W-1:0]       out_ch;
    logic                  out_valid;
    logic                  out_ready;
`ifdef RR_STREAM_MUX_LAST_EN
    logic [N_CH-1:0]       in_last;
    logic                  out_last;
`endif

    int          n_err = 0;
    int          n_chk = 0;
    logic [12:0] sb_q[$];

    always #5 clk = ~clk;

    rr_stream_mux #(
        .N_CH      (N_CH),
        .WIDTH     (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
`ifdef RR_STREAM_MUX_LAST_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int ch, input logic [7:0] d, input logic l);
        sb_q.push_back({l, 4'(ch), d});
    endtask

    task automatic set_ch(input int ch, input logic [7:0] d);
        in_data[ch*WIDTH +: WIDTH] = d;
    endtask

    // Check ready and any handshake just before the edge, then advance one clock.
    task automatic step(input logic [3:0] exp_rdy);
        logic [12:0] e;
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_beat_queue_size", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk("out_ch", 32'(out_ch), 32'(e[11:8]));
                chk("out_data", 32'(out_data), 32'(e[7:0]));
`ifdef RR_STREAM_MUX_LAST_EN
                chk("out_last", 32'(out_last), 32'(e[12]));
`endif
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        sb_q.delete();
        for (int i = 0; i < 3; i++) begin
            step(4'b0000);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_ch", 32'(out_ch), 32'd0);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = '0;
        out_ready = 1'b0;
`ifdef RR_STREAM_MUX_LAST_EN
        in_last   = 4'b1111;
`endif
        @(posedge clk);
        #1;

        // Reset, then round-robin with every channel requesting
        do_reset();
        for (int c = 0; c < N_CH; c++) set_ch(c, 8'hA0 + 8'(c));
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(i % N_CH, 8'hA0 + 8'(i % N_CH), 1'b1);
            step(4'(1 << (i % N_CH)));
        end
        in_valid = 4'b0000;
        step(4'b0000);
        chk("rr_drained_valid", 32'(out_valid), 32'd0);

        // Single requester on channel 2, served every cycle
        do_reset();
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        set_ch(2, 8'h11);
        push(2, 8'h11, 1'b1);
        step(4'b0100);
        chk("lat1_valid", 32'(out_valid), 32'd1);
        chk("lat1_data", 32'(out_data), 32'h11);
        set_ch(2, 8'h22);
        push(2, 8'h22, 1'b1);
        step(4'b0100);
        set_ch(2, 8'h33);
        push(2, 8'h33, 1'b1);
        step(4'b0100);
        in_valid = 4'b0000;
        step(4'b0000);
        chk("single_drained_valid", 32'(out_valid), 32'd0);

        // Backpressure holds the slot and blocks all grants
        do_reset();
        for (int c = 0; c < N_CH; c++) set_ch(c, 8'hA0 + 8'(c));
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        push(0, 8'hA0, 1'b1);
        step(4'b0001);
        push(1, 8'hA1, 1'b1);
        step(4'b0010);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(4'b0000);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_ch", 32'(out_ch), 32'd1);
            chk("bp_data", 32'(out_data), 32'hA1);
        end
        out_ready = 1'b1;
        push(2, 8'hA2, 1'b1);
        step(4'b0100);
        in_valid = 4'b0000;
        step(4'b0000);

        // Reset while a channel-1 beat is stalled in the slot
        do_reset();
        in_valid  = 4'b0010;
        out_ready = 1'b0;
        set_ch(1, 8'h5A);
        step(4'b0010);
        chk("mid_valid", 32'(out_valid), 32'd1);
        chk("mid_ch", 32'(out_ch), 32'd1);
        rst = 1'b1;
        step(4'b0000);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ch", 32'(out_ch), 32'd0);
        rst       = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < N_CH; c++) set_ch(c, 8'hA0 + 8'(c));
        push(0, 8'hA0, 1'b1);
        step(4'b0001);
        in_valid = 4'b0000;
        step(4'b0000);

`ifdef RR_STREAM_MUX_LAST_EN
        // Channel 0 packet of three beats locks out channel 1
        do_reset();
        in_valid  = 4'b0011;
        in_last   = 4'b0000;
        out_ready = 1'b1;
        set_ch(1, 8'hC1);
        set_ch(0, 8'hB1);
        push(0, 8'hB1, 1'b0);
        step(4'b0001);
        set_ch(0, 8'hB2);
        push(0, 8'hB2, 1'b0);
        step(4'b0001);
        set_ch(0, 8'hB3);
        in_last = 4'b0001;
        push(0, 8'hB3, 1'b1);
        step(4'b0001);
        in_valid = 4'b0010;
        in_last  = 4'b0010;
        push(1, 8'hC1, 1'b1);
        step(4'b0010);
        in_valid = 4'b0000;
        step(4'b0000);
        chk("pkt_drained_valid", 32'(out_valid), 32'd0);
`endif

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
